streaming_fifo_wm: RTL and testbench

Parametrised AXI-Stream FIFO with first-word fall-through output, occupancy count, almost-full/almost-empty flags and a peak-occupancy (high-watermark) register. Sits between dataflow layers wherever an inter-layer stream buffer is inserted. It generalises the fixed-size stream FIFO with configurable thresholds and run-time watermark capture, which feeds FIFO-depth characterisation.

---
 rtl/streaming_fifo_wm.sv | 86 ++++++++
 tb/tb_streaming_fifo_wm.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/streaming_fifo_wm.sv
// First-word fall-through AXI-Stream FIFO with occupancy count, almost-full/empty
// flags and a clearable peak-occupancy (high-watermark) register.
module streaming_fifo_wm #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 2048,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int CW        = $clog2(DEPTH + 1)
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic [WIDTH-1:0] in0_V_V_TDATA,
    input  logic             in0_V_V_TVALID,
    output logic             in0_V_V_TREADY,
    output logic [WIDTH-1:0] out_V_V_TDATA,
    output logic             out_V_V_TVALID,
    input  logic             out_V_V_TREADY,
    output logic [CW-1:0]    count,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    max_count,
    input  logic             clear_max
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;
    logic [CW-1:0]    count_next;

    // Ready never looks at the output side, so a full FIFO cannot pass a word through.
    assign in0_V_V_TREADY = !ap_rst && (count < CW'(DEPTH));
    assign out_V_V_TVALID = (count != '0);
    assign out_V_V_TDATA  = mem[rd_ptr];
    assign wr_en          = in0_V_V_TVALID && in0_V_V_TREADY;
    assign rd_en          = out_V_V_TVALID && out_V_V_TREADY;
    assign almost_full    = (count >= CW'(AF_THRESH));
    assign almost_empty   = (count <= CW'(AE_THRESH));

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        if (ptr == PW'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + PW'(1);
    endfunction

    always_comb begin
        count_next = count;
        if (wr_en && !rd_en) begin
            count_next = count + CW'(1);
        end else if (!wr_en && rd_en) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge ap_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= in0_V_V_TDATA;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            max_count <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_en) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count_next;
            // The watermark tracks the post-transfer occupancy, so a clear still sees a concurrent write.
            if (clear_max || (count_next > max_count)) begin
                max_count <= count_next;
            end
        end
    end

endmodule

// File: tb/tb_streaming_fifo_wm.sv
// Bench for streaming_fifo_wm: directed vector table, hand-written corner sequences
// and randomized traffic checked against a queue-based reference model.
module tb_streaming_fifo_wm;

    localparam int WIDTH = 16;
    localparam int DEPTH = 5;
    localparam int AF    = 4;
    localparam int AE    = 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             ap_clk;
    logic             ap_rst;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    count;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    max_count;
    logic             clear_max;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] mq[$];
    int               mmax = 0;

    typedef struct {
        logic             vin;
        logic [WIDTH-1:0] din;
        logic             rdy;
        logic             clr;
        logic             rst;
        int               e_cnt;
        logic             e_rdy;
        logic             e_vld;
        logic [WIDTH-1:0] e_dat;
        int               e_max;
    } vec_t;

    vec_t vecs[$];

    streaming_fifo_wm #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut (
        .ap_clk         (ap_clk),
        .ap_rst         (ap_rst),
        .in0_V_V_TDATA  (in_data),
        .in0_V_V_TVALID (in_valid),
        .in0_V_V_TREADY (in_ready),
        .out_V_V_TDATA  (out_data),
        .out_V_V_TVALID (out_valid),
        .out_V_V_TREADY (out_ready),
        .count          (count),
        .almost_full    (almost_full),
        .almost_empty   (almost_empty),
        .max_count      (max_count),
        .clear_max      (clear_max)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    task automatic cmp(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic vin, input int din, input logic rdy, input logic clr,
                                input logic rst, input int e_cnt, input logic e_rdy,
                                input logic e_vld, input int e_dat, input int e_max);
        vec_t v;
        v.vin = vin; v.din = WIDTH'(din); v.rdy = rdy; v.clr = clr; v.rst = rst;
        v.e_cnt = e_cnt; v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_dat = WIDTH'(e_dat);
        v.e_max = e_max;
        vecs.push_back(v);
    endfunction

    // One clock edge: drive inputs, let the model follow the handshake rules, settle.
    task automatic applyStimulus(input logic vin, input logic [WIDTH-1:0] din, input logic rdy,
                                 input logic clr, input logic rst);
        int  n;
        bit  wr;
        bit  rd;
        in_valid  = vin;
        in_data   = din;
        out_ready = rdy;
        clear_max = clr;
        ap_rst    = rst;
        @(posedge ap_clk);
        n = mq.size();
        if (rst) begin
            mq.delete();
            mmax = 0;
        end else begin
            wr = vin && (n < DEPTH);
            rd = rdy && (n > 0);
            if (rd) void'(mq.pop_front());
            if (wr) mq.push_back(din);
            if (clr || mq.size() > mmax) mmax = mq.size();
        end
        #1;
    endtask

    task automatic checkOutput();
        int n;
        n = mq.size();
        cmp("in_ready", in_ready, (!ap_rst && n < DEPTH));
        cmp("out_valid", out_valid, (n != 0));
        cmp("count", count, n);
        cmp("almost_full", almost_full, (n >= AF));
        cmp("almost_empty", almost_empty, (n <= AE));
        cmp("max_count", max_count, mmax);
        if (n != 0) cmp("out_data", out_data, mq[0]);
    endtask

    task automatic step(input logic vin, input logic [WIDTH-1:0] din, input logic rdy,
                        input logic clr, input logic rst);
        applyStimulus(vin, din, rdy, clr, rst);
        checkOutput();
    endtask

    initial begin
        ap_rst = 1'b1; in_valid = 1'b1; in_data = '0; out_ready = 1'b0; clear_max = 1'b0;

        // Reset held with valid input, then release.
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        // Fill to full, then a write attempt that must be refused.
        for (int i = 1; i <= 5; i++) add(1, i, 0, 0, 0, i, (i < 5), 1, 1, i);
        add(1, 6, 0, 0, 0, 5, 0, 1, 1, 5);
        // Drain in order.
        for (int i = 1; i <= 5; i++) add(0, 0, 1, 0, 0, 5 - i, 1, (i < 5), i + 1, 5);
        // Watermark: clear at empty, peak 4, drain to 1, clear, clear with a write.
        add(0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(1, 10 + i, 0, 0, 0, i + 1, 1, 1, 10, i + 1);
        for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 0, 3 - i, 1, 1, 11 + i, 4);
        add(0, 0, 0, 1, 0, 1, 1, 1, 13, 1);
        add(1, 14, 0, 1, 0, 2, 1, 1, 13, 2);
        add(0, 0, 1, 0, 0, 1, 1, 1, 14, 2);
        add(0, 0, 1, 0, 0, 0, 1, 0, 0, 2);

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].vin, vecs[k].din, vecs[k].rdy, vecs[k].clr, vecs[k].rst);
            cmp("tbl_count", count, vecs[k].e_cnt);
            cmp("tbl_ready", in_ready, vecs[k].e_rdy);
            cmp("tbl_valid", out_valid, vecs[k].e_vld);
            cmp("tbl_max", max_count, vecs[k].e_max);
            cmp("tbl_af", almost_full, (vecs[k].e_cnt >= AF));
            cmp("tbl_ae", almost_empty, (vecs[k].e_cnt <= AE));
            if (vecs[k].e_vld) cmp("tbl_data", out_data, vecs[k].e_dat);
            checkOutput();
        end

        // Simultaneous read and write at count 3 keeps occupancy and watermark steady.
        for (int i = 0; i < 3; i++) step(1, WIDTH'(16'h100 + i), 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, WIDTH'(16'h200 + i), 1, 0, 0);
            cmp("rw_count", count, 3);
            cmp("rw_max", max_count, 3);
        end

        // Mid-stream reset discards contents; new words emerge with nothing stale ahead.
        step(0, 0, 0, 0, 1);
        cmp("mrst_count", count, 0);
        cmp("mrst_valid", out_valid, 0);
        step(1, 16'h000A, 0, 0, 0);
        cmp("mrst_head_a", out_data, 16'h000A);
        step(1, 16'h000B, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        cmp("mrst_head_b", out_data, 16'h000B);
        step(0, 0, 1, 0, 0);
        cmp("mrst_empty", out_valid, 0);

        // Random traffic alternating between fill-biased and drain-biased phases.
        for (int i = 0; i < 400; i++) begin
            logic vin;
            logic rdy;
            vin = ($urandom_range(0, 3) != 0);
            rdy = ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step(vin, WIDTH'($urandom), rdy, ($urandom_range(0, 24) == 0), 1'b0);
        end
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
